mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multiply/divide unit in the EX stage; sits beside the ALU and takes the same forwarded operand1/operand2.
- Implements the MIPS mult, multu, div, divu, mthi, mtlo, mfhi and mflo group with architectural HI/LO registers.
- Models the multi-cycle latency with a busy counter, so the hazard unit can stall dependent MDU instructions in ID.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- start  input  1  one-cycle pulse: issue the op on MDUop this cycle.
- MDUop  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; others = none.
- operand1  input  32  rs value (multiplicand, dividend, or mthi/mtlo source).
- operand2  input  32  rt value (multiplier or divisor).
- readHi  input  1  1 selects HI, 0 selects LO on MDUOut.
- busy  output  1  registered; 1 while an operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- MDUOut  output  32  combinational: readHi ? HI : LO (for mfhi/mflo).

Behaviour:
- Reset (reset==0 at an edge):
  - HI=0, LO=0, busy=0, counter=0.
  - Pending results are discarded.
  - Reset mid-operation aborts the operation; no HI/LO write ever follows.
- Idle: counter==0, busy==0.
- Accept: start==1 && busy==0 && MDUop in 1..4 at edge k.
  - Compute the full result from the operands sampled at edge k into pendHi/pendLo.
  - Load counter = MULT_CYCLES or DIV_CYCLES; busy=1 from edge k.
- Run: each edge, counter decrements.
  - At the edge where counter==1: HI<=pendHi, LO<=pendLo, counter<=0, busy<=0.
  - Net effect: busy is high for exactly N cycles after edge k; new HI/LO are visible after edge k+N, in the same cycle busy drops.
  - HI/LO hold their old values during busy.
- mult: signed 32x32 into a 64-bit result; HI = bits[63:32], LO = bits[31:0].
- multu: same split, unsigned.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (no trap).
- divu: unsigned quotient to LO, remainder to HI.
- Divide by zero (div/divu, operand2==0):
  - The op is accepted and busy runs the full DIV_CYCLES.
  - At completion HI/LO are left unchanged.
- mthi/mtlo: start==1 && busy==0 -> HI or LO <= operand1 at the same edge. No busy, no latency.
- start==1 while busy==1:
  - Ignored entirely for all ops; no state change, no restart.
  - The hazard unit must stall instead, so this is a protocol violation that the bench checks for robustness only.
- start==1 with MDUop 0 or 7: no effect.
- MDUOut is a pure mux of the registered HI/LO.
  - mfhi/mflo in the completion cycle sees the new value.
  - Stalling mfhi/mflo while busy is the hazard unit's job.
- Pending operands are captured at accept; later operand changes during busy have no effect.

Test Plan:
- Reset then mult: reset low 2 cycles -> HI=LO=0, busy=0. Then mult 0xFFFFFFFF x 0x00000002 -> busy=1 for 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0.
- multu 0xFFFFFFFF x 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. HI/LO hold old values while busy.
- Signed div:
  - -7 / 2 (0xFFFFFFF9, 2) -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7 / 2 -> LO=3, HI=1.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: mtlo 0x1234 and mthi 0x5678 (each takes effect next edge), then div by 0 -> busy for 10 cycles; HI=0x5678, LO=0x1234 unchanged.
- Busy collision and reset: mult issued, second mult with start at busy cycle 2 is ignored; the result equals the first op, and busy lasts 5 cycles, not 7. A new div pulsed with reset low in busy cycle 4 -> busy=0, HI=LO=0, and no later write occurs.
- MDUOut mux: HI=0xAAAA0000, LO=0x0000BBBB -> readHi=1 gives 0xAAAA0000; readHi=0 gives 0x0000BBBB, same cycle.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: HI/LO registers plus a busy counter
// that models the multi-cycle latency of mult/multu/div/divu.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDUop,
   input  logic [31:0] operand1,
   input  logic [31:0] operand2,
   input  logic        readHi,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut
);

   // state  | meaning
   // S_IDLE | no operation in flight; mult/div/mthi/mtlo accepted
   // S_RUN  | result pending; counter runs down, HI/LO written when it hits 1

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [31:0]      hi_nxt, lo_nxt;
   logic [31:0]      pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
   logic             pend_wr, pend_wr_nxt;

   logic [63:0]      prod_s, prod_u;
   logic [31:0]      mag_a, mag_b, quo_u, rem_u, quo_m, rem_m;
   logic             div_zero;
   logic [31:0]      res_hi, res_lo;
   logic             res_valid;

   // Full result of the op on the current operands. Signed divide works on
   // magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0 without overflow.
   always_comb begin
      prod_s   = $signed({{32{operand1[31]}}, operand1}) * $signed({{32{operand2[31]}}, operand2});
      prod_u   = {32'd0, operand1} * {32'd0, operand2};
      mag_a    = operand1[31] ? (~operand1 + 32'd1) : operand1;
      mag_b    = operand2[31] ? (~operand2 + 32'd1) : operand2;
      div_zero = (operand2 == 32'd0);
      quo_u    = div_zero ? 32'd0 : operand1 / operand2;
      rem_u    = div_zero ? 32'd0 : operand1 % operand2;
      quo_m    = div_zero ? 32'd0 : mag_a / mag_b;
      rem_m    = div_zero ? 32'd0 : mag_a % mag_b;
      res_hi    = 32'd0;
      res_lo    = 32'd0;
      res_valid = 1'b1;
      case (MDUop)
         OP_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         OP_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         OP_DIV: begin
            res_lo    = (operand1[31] ^ operand2[31]) ? (~quo_m + 32'd1) : quo_m;
            res_hi    = operand1[31] ? (~rem_m + 32'd1) : rem_m;
            res_valid = ~div_zero;
         end
         OP_DIVU: begin
            res_lo    = quo_u;
            res_hi    = rem_u;
            res_valid = ~div_zero;
         end
         default: res_valid = 1'b0;
      endcase
   end

   // Next-state: accept ops only when idle, run the counter down while busy.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      hi_nxt      = HI;
      lo_nxt      = LO;
      pend_hi_nxt = pend_hi;
      pend_lo_nxt = pend_lo;
      pend_wr_nxt = pend_wr;
      case (state)
         S_IDLE: begin
            if (start) begin
               case (MDUop)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     pend_hi_nxt = res_hi;
                     pend_lo_nxt = res_lo;
                     pend_wr_nxt = res_valid;
                     cnt_nxt     = (MDUop == OP_MULT || MDUop == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                     state_nxt   = S_RUN;
                  end
                  OP_MTHI: hi_nxt = operand1;
                  OP_MTLO: lo_nxt = operand1;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
               if (pend_wr) begin
                  hi_nxt = pend_hi;
                  lo_nxt = pend_lo;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Registers; reset discards any pending result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         HI      <= 32'd0;
         LO      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         HI      <= hi_nxt;
         LO      <= lo_nxt;
         pend_hi <= pend_hi_nxt;
         pend_lo <= pend_lo_nxt;
         pend_wr <= pend_wr_nxt;
      end
   end

   assign busy   = (state == S_RUN);
   assign MDUOut = readHi ? HI : LO;

endmodule

// File: tb/tb_mdu.sv
// Directed and randomized checks of mdu against a behavioural HI/LO model.
module tb_mdu;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  MDUop;
   logic [31:0] operand1, operand2;
   logic        readHi;
   logic        busy;
   logic [31:0] HI, LO, MDUOut;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   bit          m_pv;
   int          m_rem;

   mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .start(start), .MDUop(MDUop),
      .operand1(operand1), .operand2(operand2), .readHi(readHi),
      .busy(busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural result of an MDU op using plain 64-bit arithmetic.
   task automatic compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output bit valid);
      longint      p, q, r;
      logic [63:0] pu;
      hi = 32'd0; lo = 32'd0; valid = 1'b1;
      case (op)
         3'd1: begin
            p  = longint'($signed(a)) * longint'($signed(b));
            hi = p[63:32]; lo = p[31:0];
         end
         3'd2: begin
            pu = 64'(a) * 64'(b);
            hi = pu[63:32]; lo = pu[31:0];
         end
         3'd3: begin
            if (b == 32'd0) valid = 1'b0;
            else begin
               q  = longint'($signed(a)) / longint'($signed(b));
               r  = longint'($signed(a)) % longint'($signed(b));
               lo = q[31:0]; hi = r[31:0];
            end
         end
         3'd4: begin
            if (b == 32'd0) valid = 1'b0;
            else begin
               lo = a / b; hi = a % b;
            end
         end
         default: valid = 1'b0;
      endcase
   endtask

   // One clock edge: advance the model on the inputs present at the edge, then compare.
   task automatic tick();
      logic [31:0] h, l;
      bit          v;
      @(posedge clk);
      if (!reset) begin
         m_hi = 32'd0; m_lo = 32'd0; m_rem = 0; m_pv = 1'b0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0 && m_pv) begin
            m_hi = m_phi; m_lo = m_plo;
         end
      end else if (start) begin
         if (MDUop >= 3'd1 && MDUop <= 3'd4) begin
            compute(MDUop, operand1, operand2, h, l, v);
            m_phi = h; m_plo = l; m_pv = v;
            m_rem = (MDUop <= 3'd2) ? MULT_N : DIV_N;
         end else if (MDUop == 3'd5) m_hi = operand1;
         else if (MDUop == 3'd6) m_lo = operand1;
      end
      #1;
      check("busy", 32'(busy), 32'(m_rem != 0));
      check("HI", HI, m_hi);
      check("LO", LO, m_lo);
      check("MDUOut", MDUOut, readHi ? m_hi : m_lo);
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; MDUop = op; operand1 = a; operand2 = b;
      tick();
      start = 1'b0; MDUop = 3'd0;
      operand1 = $urandom; operand2 = $urandom;
   endtask

   // Counts edges until busy falls (bounded); returns the count.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      reset = 1'b0; start = 1'b0; MDUop = 3'd0;
      operand1 = 32'd0; operand2 = 32'd0; readHi = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_pv = 1'b0; m_rem = 0;

      // reset
      tick(); tick();
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      tick();

      // signed mult
      issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
      wait_idle(n);
      check("mult_len", n, MULT_N);
      check("mult_hi", HI, 32'hFFFF_FFFF);
      check("mult_lo", LO, 32'hFFFF_FFFE);

      // unsigned mult
      issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
      check("multu_hold_hi", HI, 32'hFFFF_FFFF);
      wait_idle(n);
      check("multu_len", n, MULT_N);
      check("multu_hi", HI, 32'h0000_0001);
      check("multu_lo", LO, 32'hFFFF_FFFE);

      // signed / unsigned divide
      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      check("div_len", n, DIV_N);
      check("div_lo", LO, 32'hFFFF_FFFD);
      check("div_hi", HI, 32'hFFFF_FFFF);
      issue(3'd4, 32'd7, 32'd2);
      wait_idle(n);
      check("divu_lo", LO, 32'd3);
      check("divu_hi", HI, 32'd1);
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      check("divovf_lo", LO, 32'h8000_0000);
      check("divovf_hi", HI, 32'd0);

      // divide by zero keeps HI/LO
      issue(3'd6, 32'h0000_1234, 32'd0);
      check("mtlo", LO, 32'h0000_1234);
      issue(3'd5, 32'h0000_5678, 32'd0);
      check("mthi", HI, 32'h0000_5678);
      issue(3'd3, 32'd99, 32'd0);
      wait_idle(n);
      check("div0_len", n, DIV_N);
      check("div0_hi", HI, 32'h0000_5678);
      check("div0_lo", LO, 32'h0000_1234);

      // start while busy is ignored
      issue(3'd1, 32'd3, 32'd4);
      tick();
      start = 1'b1; MDUop = 3'd1; operand1 = 32'd100; operand2 = 32'd100;
      tick();
      start = 1'b0; MDUop = 3'd0;
      wait_idle(n);
      check("collide_len", n + 2, MULT_N);
      check("collide_lo", LO, 32'd12);
      check("collide_hi", HI, 32'd0);

      // reset in busy cycle 4 aborts the divide
      issue(3'd4, 32'd100, 32'd7);
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_hi", HI, 32'd0);
      check("abort_lo", LO, 32'd0);
      repeat (12) tick();
      check("abort_late_lo", LO, 32'd0);

      // MDUOut mux, same cycle
      issue(3'd5, 32'hAAAA_0000, 32'd0);
      issue(3'd6, 32'h0000_BBBB, 32'd0);
      readHi = 1'b1; #1;
      check("mux_hi", MDUOut, 32'hAAAA_0000);
      readHi = 1'b0; #1;
      check("mux_lo", MDUOut, 32'h0000_BBBB);

      // randomized traffic, including collisions and occasional resets
      for (int i = 0; i < 400; i++) begin
         start    = ($urandom_range(0, 1) == 1);
         MDUop    = 3'($urandom_range(0, 7));
         operand1 = $urandom;
         operand2 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) operand1 = 32'h8000_0000;
         if ($urandom_range(0, 7) == 0) operand2 = 32'hFFFF_FFFF;
         readHi   = ($urandom_range(0, 1) == 1);
         reset    = ($urandom_range(0, 63) != 0);
         tick();
      end
      start = 1'b0; reset = 1'b1;
      repeat (12) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
